// File: rtl/reminder_alert_ctrl_if.sv
// reminder_alert_ctrl_if: alert controller signal bundle.
//   master: drives tick_1hz, remind, ack; observes buzzer, led, alert_active, miss_cnt, missed
//   slave : the controller side of the same signals
interface reminder_alert_ctrl_if;
    logic       tick_1hz;
    logic       remind;
    logic       ack;
    logic       buzzer;
    logic       led;
    logic       alert_active;
    logic [2:0] miss_cnt;
    logic       missed;
    modport master(output tick_1hz, remind, ack, input buzzer, led, alert_active, miss_cnt, missed);
    modport slave(input tick_1hz, remind, ack, output buzzer, led, alert_active, miss_cnt, missed);
endinterface

// File: rtl/reminder_alert_ctrl.sv
// reminder_alert_ctrl: hydration alert sequencer (IDLE/ALERT/SNOOZE/MISSED) driving buzzer and LED.
//   clk, reset (async, active-high)
//   bus.tick_1hz/remind/ack in; bus.buzzer/led/alert_active/miss_cnt/missed out (all registered)
module reminder_alert_ctrl #(
    parameter int BEEP_ON_S   = 1,
    parameter int BEEP_OFF_S  = 1,
    parameter int ALERT_LEN_S = 30,
    parameter int SNOOZE_S    = 600,
    parameter int MAX_MISS    = 3
) (
    input logic                  clk,
    input logic                  reset,
    reminder_alert_ctrl_if.slave bus
);
    localparam int SMAX = ALERT_LEN_S > SNOOZE_S ? ALERT_LEN_S : SNOOZE_S;
    localparam int PMAX = BEEP_ON_S > BEEP_OFF_S ? BEEP_ON_S : BEEP_OFF_S;
    localparam int SW   = $clog2(SMAX + 1);
    localparam int PW   = $clog2(PMAX + 1);

    typedef enum logic [1:0] {IDLE, ALERT, SNOOZE, MISSED} state_t;

    state_t          state, state_n;
    logic [SW-1:0]   sec_cnt, sec_n;
    logic [PW-1:0]   ph_cnt, ph_n, ph_inc, ph_len;
    logic            phase, phase_n;
    logic [2:0]      miss_r, miss_n;
    logic            led_r, led_n, buz_r, act_r, mis_r;

    assign ph_inc = ph_cnt + PW'(1);
    assign ph_len = phase ? PW'(BEEP_ON_S) : PW'(BEEP_OFF_S);

    always_comb begin
        state_n = state;
        sec_n   = sec_cnt;
        ph_n    = ph_cnt;
        phase_n = phase;
        miss_n  = miss_r;
        case (state)
            IDLE: if (bus.remind) state_n = ALERT;
            ALERT: begin
                if (!bus.remind) state_n = IDLE;
                else if (bus.ack) begin
                    state_n = SNOOZE;
                    miss_n  = '0;
                end else if (bus.tick_1hz && sec_cnt == SW'(ALERT_LEN_S - 1)) begin
                    state_n = (miss_r + 3'd1 == 3'(MAX_MISS)) ? MISSED : SNOOZE;
                    miss_n  = miss_r + 3'd1;
                end else if (bus.tick_1hz) begin
                    sec_n   = sec_cnt + SW'(1);
                    ph_n    = (ph_inc == ph_len) ? '0 : ph_inc;
                    phase_n = (ph_inc == ph_len) ? ~phase : phase;
                end
            end
            SNOOZE: begin
                if (!bus.remind) state_n = IDLE;
                else if (bus.tick_1hz && sec_cnt == SW'(SNOOZE_S - 1)) state_n = ALERT;
                else if (bus.tick_1hz) sec_n = sec_cnt + SW'(1);
            end
            MISSED: if (!bus.remind || bus.ack) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Every state change reloads the counters so ALERT always restarts at phase ON.
        if (state_n != state) begin
            sec_n   = '0;
            ph_n    = '0;
            phase_n = 1'b1;
        end
        if (state_n == IDLE) miss_n = '0;
        // SNOOZE blinks from 0 on entry, toggling once per tick while it stays.
        led_n = (state_n == ALERT || state_n == MISSED) ? 1'b1 :
                (state_n == SNOOZE && state == SNOOZE) ? led_r ^ bus.tick_1hz : 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            sec_cnt <= '0;
            ph_cnt  <= '0;
            phase   <= 1'b0;
            miss_r  <= '0;
            led_r   <= 1'b0;
            buz_r   <= 1'b0;
            act_r   <= 1'b0;
            mis_r   <= 1'b0;
        end else begin
            state   <= state_n;
            sec_cnt <= sec_n;
            ph_cnt  <= ph_n;
            phase   <= phase_n;
            miss_r  <= miss_n;
            led_r   <= led_n;
            buz_r   <= state_n == ALERT && phase_n;
            act_r   <= state_n == ALERT;
            mis_r   <= state_n == MISSED;
        end
    end

    assign bus.buzzer       = buz_r;
    assign bus.led          = led_r;
    assign bus.alert_active = act_r;
    assign bus.miss_cnt     = miss_r;
    assign bus.missed       = mis_r;
endmodule

// File: doc/reminder_alert_ctrl.md
Name: reminder_alert_ctrl

Overview:
- Sequences the user-facing alert for the hydration reminder.
- Consumes the registered remind level from the reminder logic and a 1 Hz tick from the clock/timekeeping chain.
- Drives the buzzer and status LED through alert, snooze and missed-reminder phases, with acknowledge and escalation handling.
- Sits between the reminder logic and the board I/O (buzzer pin, LED, debounced ack button).

Parameters:
- BEEP_ON_S, 1, tick_1hz periods the buzzer is on per beep cycle (>=1)
- BEEP_OFF_S, 1, tick_1hz periods the buzzer is off per beep cycle (>=1)
- ALERT_LEN_S, 30, tick_1hz periods an ALERT lasts before it times out (>=1)
- SNOOZE_S, 600, tick_1hz periods spent in SNOOZE (>=1)
- MAX_MISS, 3, consecutive unacknowledged timeouts before entering MISSED (1..7)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick_1hz  in  1  one-clk pulse per second
- remind  in  1  level, 1 = water still due
- ack  in  1  one-clk pulse from the debounced ack button
- buzzer  out  1  buzzer enable
- led  out  1  status LED
- alert_active  out  1  high in ALERT
- miss_cnt  out  3  consecutive timeouts since last ack or IDLE
- missed  out  1  high in MISSED

Behaviour:
- Reset (async, reset=1): state=IDLE; all counters 0; buzzer=0, led=0, alert_active=0, miss_cnt=0, missed=0.
- All outputs are registered. They reflect the state and counters after each clk edge. A transition sampled on edge k is visible on the outputs immediately after edge k.
- Counters:
  - sec_cnt: wide enough for max(ALERT_LEN_S, SNOOZE_S).
  - ph_cnt: wide enough for max(BEEP_ON_S, BEEP_OFF_S).
  - phase bit: ON or OFF.
- Events are evaluated once per clk, in priority order: remind==0, then ack, then timeout (tick), then tick alone.
- IDLE:
  - Outputs: buzzer=0, led=0, miss_cnt=0.
  - remind==1 -> ALERT, with sec_cnt=0, ph_cnt=0, phase=ON.
- ALERT:
  - Outputs: alert_active=1, led=1, buzzer=(phase==ON).
  - Each tick: ph_cnt++. When ph_cnt reaches the current phase length, phase toggles and ph_cnt=0.
  - Each tick: sec_cnt++.
  - remind==0 -> IDLE. Counters and miss_cnt are cleared.
  - ack -> SNOOZE, with miss_cnt=0 and sec_cnt=0. A tick in the same cycle is ignored.
  - Timeout: a tick with sec_cnt==ALERT_LEN_S-1.
    - If miss_cnt+1 == MAX_MISS: -> MISSED, miss_cnt=MAX_MISS.
    - Otherwise: -> SNOOZE, miss_cnt++, sec_cnt=0.
- SNOOZE:
  - Outputs: buzzer=0; led toggles on every tick (starts at 0 on entry).
  - remind==0 -> IDLE.
  - Ack is ignored.
  - Tick with sec_cnt==SNOOZE_S-1 -> ALERT, with sec_cnt=0, ph_cnt=0, phase=ON.
  - Otherwise each tick: sec_cnt++.
- MISSED:
  - Outputs: buzzer=0, led=1, missed=1. miss_cnt holds at MAX_MISS.
  - remind==0 -> IDLE.
  - ack -> IDLE; all counters are cleared.
  - Ticks are ignored.
- Re-entering ALERT always restarts the beep pattern at phase ON.
- Counters never wrap. Every terminal compare forces a transition that reloads them.
- No tick for an extended period: the state holds indefinitely, with outputs unchanged.
- Reset asserted mid-ALERT or mid-SNOOZE: outputs drop to 0 asynchronously. After deassertion the block resumes from IDLE. If remind is still 1, it re-enters ALERT on the first clk edge.
- Glitch-free requirement: buzzer and led change only on clk edges.

Test Plan:
- Basic alert: reset, then remind=1 -> alert_active=1 and buzzer=1 on the next edge. With default params, buzzer toggles after each tick (1,0,1,...); led=1 steady.
- Ack: in ALERT, pulse ack after 5 ticks -> SNOOZE with buzzer=0, miss_cnt=0. After 600 ticks -> ALERT with buzzer=1.
- Escalation: hold remind=1 with no ack for 3×30 alert ticks plus 2×600 snooze ticks:
  - miss_cnt steps 1, 2.
  - On the 3rd timeout: missed=1, led=1, buzzer=0, miss_cnt=3.
  - A following ack -> IDLE with all outputs 0.
- Drink mid-sequence: remind falls during ALERT, SNOOZE and MISSED (three separate runs) -> IDLE on the next edge with all outputs 0.
- Simultaneous events:
  - ack and the timeout tick in the same cycle -> SNOOZE with miss_cnt=0.
  - remind=0 and ack in the same cycle -> IDLE.
- Async reset: assert reset between clk edges during ALERT -> buzzer, led and alert_active go to 0 without a clk edge. Release with remind=1 -> ALERT on the first edge, beep phase ON.
